// File: rtl/usb_frame_ctrl.sv
// rtl/usb_frame_ctrl.sv - frame hunter/validator between the USB byte reader and the payload buffer
// Parses SYNC,CMD,LEN,payload,CSUM frames; writes payload with zero latency and reports done/error pulses.
module usb_frame_ctrl #(
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         MAX_LEN = 64,
    parameter int         AW      = 6,
    parameter int         TIMEOUT = 100000,
    parameter int         TW      = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          hold,
    input  logic          wr_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          frame_done,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic [7:0]    cmd,
    output logic [7:0]    len,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_VAL   = TW'(TIMEOUT);

    state_t        st;
    logic [7:0]    acc;
    logic [AW-1:0] idx;
    logic [TW-1:0] timer;
    logic          in_frame;
    logic          tmo;
    logic          take;

    assign state = st;

    // A timeout wins over a byte arriving in the same cycle, so that byte stays with the reader.
    always_comb begin
        in_frame = (st == S_CMD) || (st == S_LEN) || (st == S_PAYLOAD) || (st == S_CSUM);
        hold     = ((st == S_PAYLOAD) && !wr_ready) || (st == S_DONE);
        tmo      = in_frame && (timer == TMO_VAL);
        take     = byte_valid && !hold && !tmo;
        wr_en    = (st == S_PAYLOAD) && take;
        wr_addr  = idx;
        wr_data  = byte_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= S_IDLE;
            acc        <= '0;
            idx        <= '0;
            timer      <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'd0;
            cmd        <= 8'd0;
            len        <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (take || !in_frame)
                timer <= '0;
            else if (!hold)
                timer <= timer + TW'(1);

            if (tmo) begin
                frame_err <= 1'b1;
                err_code  <= 2'd3;
                st        <= S_IDLE;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (take && byte_in == SYNC) begin
                            acc <= 8'd0;
                            idx <= '0;
                            st  <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (take) begin
                            cmd <= byte_in;
                            acc <= byte_in;
                            st  <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (take) begin
                            len <= byte_in;
                            acc <= acc + byte_in;
                            if (byte_in > MAX_LEN_B) begin
                                frame_err <= 1'b1;
                                err_code  <= 2'd2;
                                st        <= S_IDLE;
                            end else if (byte_in == 8'd0) begin
                                st <= S_CSUM;
                            end else begin
                                st <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (take) begin
                            acc <= acc + byte_in;
                            idx <= idx + AW'(1);
                            if (8'(idx) == len - 8'd1)
                                st <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (take) begin
                            if (byte_in == acc) begin
                                frame_done <= 1'b1;
                                st         <= S_DONE;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= 2'd1;
                                st        <= S_IDLE;
                            end
                        end
                    end
                    S_DONE:  st <= S_IDLE;
                    default: st <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_frame_ctrl.sv
// tb/tb_usb_frame_ctrl.sv - self-checking bench for usb_frame_ctrl
// Directed frames plus random streams compared against a byte-stream frame parser model.
module tb_usb_frame_ctrl;
    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         MAX_LEN = 64;
    localparam int         AW      = 6;
    localparam int         TIMEOUT = 20;
    localparam int         TW      = 17;
    localparam logic [31:0] EV_DONE = 32'h0001_0000;
    localparam logic [31:0] EV_ERR  = 32'h0002_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          hold;
    logic          wr_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          frame_done;
    logic          frame_err;
    logic [1:0]    err_code;
    logic [7:0]    cmd;
    logic [7:0]    len;
    logic [2:0]    state;

    usb_frame_ctrl #(
        .SYNC(SYNC), .MAX_LEN(MAX_LEN), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)
    ) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .hold(hold), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code), .cmd(cmd), .len(len), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] got_w[$], got_e[$], exp_w[$], exp_e[$];
    logic [7:0]  stim[$];
    int viol_both = 0, viol_lat = 0, viol_wr = 0;
    int cyc = 0, last_acc = -10;
    bit rdy_rand = 1'b0;

    always @(posedge clk) begin
        #1;
        if (rdy_rand) wr_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (frame_done && frame_err) viol_both++;
            if ((frame_done || (frame_err && err_code != 2'd3)) && (cyc - last_acc != 1)) viol_lat++;
            if (frame_done) got_e.push_back(EV_DONE | {16'd0, cmd, len});
            if (frame_err)  got_e.push_back(EV_ERR | {30'd0, err_code});
            if (wr_en) begin
                if (hold || state != 3'd3 || int'(wr_addr) >= int'(len)) viol_wr++;
                got_w.push_back({16'd0, 2'b00, wr_addr, wr_data});
            end
            if (byte_valid && !hold) last_acc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        bit  took = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!took && n < 1000) begin
            @(negedge clk);
            took = !hold;
            @(posedge clk);
            #1;
            n++;
        end
        byte_valid = 1'b0;
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL send_byte: byte %0h never accepted after %0d cycles", b, n);
        end
    endtask

    // Reference: walk the byte stream with the frame grammar; a frame cut short by the end of the stream times out.
    task automatic model_stream();
        int i = 0;
        bit trunc = 1'b0;
        logic [7:0] c, l, sum;
        exp_w.delete();
        exp_e.delete();
        while (i < stim.size() && !trunc) begin
            if (stim[i] != SYNC) begin
                i++;
            end else if (i + 2 >= stim.size()) begin
                trunc = 1'b1;
            end else begin
                c = stim[i+1];
                l = stim[i+2];
                i += 3;
                if (int'(l) > MAX_LEN) begin
                    exp_e.push_back(EV_ERR | 32'd2);
                end else begin
                    sum = c + l;
                    for (int k = 0; k < int'(l) && !trunc; k++) begin
                        if (i >= stim.size()) begin
                            trunc = 1'b1;
                        end else begin
                            exp_w.push_back({16'd0, 8'(k), stim[i]});
                            sum += stim[i];
                            i++;
                        end
                    end
                    if (!trunc && i >= stim.size()) trunc = 1'b1;
                    if (!trunc) begin
                        exp_e.push_back(stim[i] == sum ? (EV_DONE | {16'd0, c, l}) : (EV_ERR | 32'd1));
                        i++;
                    end
                end
            end
        end
        if (trunc) exp_e.push_back(EV_ERR | 32'd3);
    endtask

    task automatic run_stream(input int settle);
        model_stream();
        got_w.delete();
        got_e.delete();
        foreach (stim[i]) begin
            send_byte(stim[i]);
            tick($urandom_range(0, 2));
        end
        rdy_rand = 1'b0;
        wr_ready = 1'b1;
        tick(settle);
    endtask

    task automatic gen_random(input int nframes);
        logic [7:0] c, l, s, b;
        int kind;
        stim.delete();
        repeat (nframes) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom);
                    if (b == SYNC) b = 8'h00;
                    stim.push_back(b);
                end
            end else begin
                c = 8'($urandom);
                case (kind)
                    1:       l = 8'd0;
                    2:       l = 8'(MAX_LEN);
                    3:       l = 8'($urandom_range(MAX_LEN + 1, 255));
                    default: l = 8'($urandom_range(1, 12));
                endcase
                stim.push_back(SYNC);
                stim.push_back(c);
                stim.push_back(l);
                if (kind != 3) begin
                    s = c + l;
                    for (int k = 0; k < int'(l); k++) begin
                        b = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
                        s += b;
                        stim.push_back(b);
                    end
                    if (kind == 4) s += 8'($urandom_range(1, 255));
                    stim.push_back(s);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs[8];
        logic [7:0] want[8];
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        @(negedge clk);
        obs  = '{8'(state), 8'(hold), 8'(wr_en), 8'(frame_done), 8'(frame_err), 8'(err_code), cmd, len};
        want = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== want[i]) begin
                failures++;
                $display("FAIL reset_state[%0d]: got %0h want %0h", i, obs[i], want[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_frames();
        int n_ev[4]  = '{1, 1, 2, 2};
        int n_wr[4]  = '{2, 0, 4, 0};
        logic [7:0] w_cmd[4] = '{8'h01, 8'h07, 8'h01, 8'h03};
        logic [7:0] w_len[4] = '{8'h02, 8'h00, 8'h02, 8'h00};
        logic [1:0] w_ec[4]  = '{2'd0, 2'd0, 2'd1, 2'd2};
        rdy_rand = 1'b0;
        wr_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: stim = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
                1: stim = '{8'hA5, 8'h07, 8'h00, 8'h07};
                2: stim = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34,
                            8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
                default: stim = '{8'hA5, 8'h01, 8'h41, 8'h10, 8'h20, 8'hA5, 8'h03, 8'h00, 8'h03};
            endcase
            run_stream(5);
            checks += 5;
            if (got_e.size() != n_ev[t]) begin
                failures++;
                $display("FAIL frames%0d_event_count: got %0d want %0d", t, got_e.size(), n_ev[t]);
            end
            if (got_w.size() != n_wr[t]) begin
                failures++;
                $display("FAIL frames%0d_write_count: got %0d want %0d", t, got_w.size(), n_wr[t]);
            end
            if (cmd !== w_cmd[t]) begin
                failures++;
                $display("FAIL frames%0d_cmd: got %0h want %0h", t, cmd, w_cmd[t]);
            end
            if (len !== w_len[t]) begin
                failures++;
                $display("FAIL frames%0d_len: got %0h want %0h", t, len, w_len[t]);
            end
            if (err_code !== w_ec[t]) begin
                failures++;
                $display("FAIL frames%0d_err_code: got %0d want %0d", t, err_code, w_ec[t]);
            end
            for (int i = 0; i < exp_w.size(); i++) begin
                checks++;
                if (i >= got_w.size() || got_w[i] !== exp_w[i]) begin
                    failures++;
                    $display("FAIL frames%0d_write[%0d]: got %0h want %0h", t, i,
                             (i < got_w.size()) ? got_w[i] : 32'hFFFF_FFFF, exp_w[i]);
                end
            end
            for (int i = 0; i < exp_e.size(); i++) begin
                checks++;
                if (i >= got_e.size() || got_e[i] !== exp_e[i]) begin
                    failures++;
                    $display("FAIL frames%0d_event[%0d]: got %0h want %0h", t, i,
                             (i < got_e.size()) ? got_e[i] : 32'hFFFF_FFFF, exp_e[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int hold_bad = 0;
        rdy_rand = 1'b0;
        wr_ready = 1'b1;
        got_w.delete();
        got_e.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h10);
        wr_ready   = 1'b0;
        byte_in    = 8'h20;
        byte_valid = 1'b1;
        repeat (TIMEOUT + 5) begin
            @(negedge clk);
            if (hold !== 1'b1 || wr_en !== 1'b0) hold_bad++;
            @(posedge clk);
            #1;
        end
        checks += 2;
        if (hold_bad != 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d bad cycles want 0", hold_bad);
        end
        if (got_e.size() != 0) begin
            failures++;
            $display("FAIL bp_timer_frozen: got %0d events want 0", got_e.size());
        end
        wr_ready = 1'b1;
        send_byte(8'h20);
        send_byte(8'h33);
        tick(3);
        checks += 3;
        if (got_w.size() != 2 || got_w[0] !== 32'h0000_0010 || got_w[1] !== 32'h0000_0120) begin
            failures++;
            $display("FAIL bp_writes: got %0d writes last %0h want 2 writes 10,120", got_w.size(),
                     (got_w.size() > 0) ? got_w[got_w.size()-1] : 32'hFFFF_FFFF);
        end
        if (got_e.size() != 1 || got_e[0] !== (EV_DONE | 32'h0102)) begin
            failures++;
            $display("FAIL bp_done: got %0d events first %0h want 1 event %0h", got_e.size(),
                     (got_e.size() > 0) ? got_e[0] : 32'hFFFF_FFFF, EV_DONE | 32'h0102);
        end
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL bp_state: got %0d want 0", state);
        end
    endtask

    task automatic test_timeout();
        int seen = 0;
        rdy_rand = 1'b0;
        wr_ready = 1'b1;
        send_byte(8'hA5);
        send_byte(8'h01);
        for (int k = 1; k <= TIMEOUT + 10 && seen == 0; k++) begin
            @(negedge clk);
            if (frame_err) seen = k;
            @(posedge clk);
            #1;
        end
        checks += 3;
        if (seen != TIMEOUT + 2) begin
            failures++;
            $display("FAIL tmo_latency: got %0d want %0d", seen, TIMEOUT + 2);
        end
        if (err_code !== 2'd3) begin
            failures++;
            $display("FAIL tmo_code: got %0d want 3", err_code);
        end
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL tmo_state: got %0d want 0", state);
        end
        // A byte presented exactly in the timeout cycle must be left for the next frame hunt.
        got_e.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        tick(TIMEOUT);
        byte_in    = SYNC;
        byte_valid = 1'b1;
        tick(2);
        byte_valid = 1'b0;
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h07);
        tick(3);
        checks++;
        if (got_e.size() != 2 || got_e[0] !== (EV_ERR | 32'd3) || got_e[1] !== (EV_DONE | 32'h0700)) begin
            failures++;
            $display("FAIL tmo_inflight: got %0d events first %0h want err3 then done 0700", got_e.size(),
                     (got_e.size() > 0) ? got_e[0] : 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_reset_mid();
        rdy_rand = 1'b0;
        wr_ready = 1'b1;
        got_e.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h05);
        send_byte(8'h10);
        send_byte(8'h20);
        wr_ready   = 1'b0;
        byte_in    = 8'h30;
        byte_valid = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        checks += 5;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid_state: got %0d want 0", state);
        end
        if (hold !== 1'b0 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_hold_wr: got hold=%0b wr_en=%0b want 0 0", hold, wr_en);
        end
        if (cmd !== 8'd0 || len !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_cmd_len: got %0h %0h want 0 0", cmd, len);
        end
        if (err_code !== 2'd0) begin
            failures++;
            $display("FAIL rst_mid_err_code: got %0d want 0", err_code);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        wr_ready   = 1'b1;
        tick(TIMEOUT + 20);
        if (got_e.size() != 0) begin
            failures++;
            $display("FAIL rst_mid_no_pulse: got %0d events want 0", got_e.size());
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            gen_random(30);
            rdy_rand = 1'b1;
            run_stream(200);
            checks += 2;
            if (got_w.size() != exp_w.size()) begin
                failures++;
                $display("FAIL rand%0d_write_count: got %0d want %0d", r, got_w.size(), exp_w.size());
            end
            if (got_e.size() != exp_e.size()) begin
                failures++;
                $display("FAIL rand%0d_event_count: got %0d want %0d", r, got_e.size(), exp_e.size());
            end
            for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
                checks++;
                if (got_w[i] !== exp_w[i]) begin
                    failures++;
                    $display("FAIL rand%0d_write[%0d]: got %0h want %0h", r, i, got_w[i], exp_w[i]);
                end
            end
            for (int i = 0; i < exp_e.size() && i < got_e.size(); i++) begin
                checks++;
                if (got_e[i] !== exp_e[i]) begin
                    failures++;
                    $display("FAIL rand%0d_event[%0d]: got %0h want %0h", r, i, got_e[i], exp_e[i]);
                end
            end
        end
        checks += 3;
        if (viol_both != 0) begin
            failures++;
            $display("FAIL both_pulses: got %0d cycles want 0", viol_both);
        end
        if (viol_lat != 0) begin
            failures++;
            $display("FAIL pulse_latency: got %0d late pulses want 0", viol_lat);
        end
        if (viol_wr != 0) begin
            failures++;
            $display("FAIL write_rules: got %0d bad writes want 0", viol_wr);
        end
    endtask

    initial begin
        reset      = 1'b1;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        wr_ready   = 1'b1;
        test_reset();
        test_frames();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
